// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable data memory between instruction fetch and load/store.
// Grants are combinational; responses come back one cycle later from a registered stage.
module mem_port_arbiter #(
   parameter int MEM_BYTES    = 4096,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_func3,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_func3,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   localparam logic [2:0] F3_WORD = 3'b010;

   logic [3:0]  starve_cnt_reg;
   logic [3:0]  starve_cnt_next;
   logic        fetch_win;
   logic        data_win;
   logic        if_bad;
   logic        d_bad;
   logic        d_func3_ok;
   logic        if_rvalid_reg;
   logic        if_err_reg;
   logic [31:0] if_rdata_reg;
   logic        d_rvalid_reg;
   logic        d_err_reg;
   logic [31:0] d_rdata_reg;

   function automatic logic out_of_range(input logic [31:0] addr, input logic [1:0] sz);
      logic [31:0] size;
      size = (sz == 2'b00) ? 32'd1 : (sz == 2'b01) ? 32'd2 : 32'd4;
      return addr > (32'(MEM_BYTES) - size);
   endfunction

   always_comb begin
      d_func3_ok = 1'b0;
      if (d_we)
         d_func3_ok = (d_func3 == 3'b000) || (d_func3 == 3'b001) || (d_func3 == 3'b010);
      else
         d_func3_ok = (d_func3 == 3'b000) || (d_func3 == 3'b001) || (d_func3 == 3'b010) ||
                      (d_func3 == 3'b100) || (d_func3 == 3'b101);
   end

   assign if_bad = out_of_range(if_addr, F3_WORD[1:0]);
   assign d_bad  = !d_func3_ok || out_of_range(d_addr, d_func3[1:0]);

   // Gating with rst_n keeps a store granted in the reset cycle from reaching memory.
   assign fetch_win = rst_n && if_req && (!d_req || (starve_cnt_reg == LIMIT));
   assign data_win  = rst_n && d_req && !fetch_win;
   assign if_gnt    = fetch_win;
   assign d_gnt     = data_win;

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_func3 = '0;
      mem_wdata = '0;
      if (fetch_win) begin
         mem_addr  = if_addr;
         mem_func3 = F3_WORD;
         mem_read  = !if_bad;
      end else if (data_win) begin
         mem_addr  = d_addr;
         mem_func3 = d_func3;
         mem_read  = !d_bad && !d_we;
         mem_write = !d_bad && d_we;
         if (!d_bad && d_we)
            mem_wdata = d_wdata;
      end
   end

   always_comb begin
      starve_cnt_next = '0;
      if (if_req && !fetch_win)
         starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_reg <= '0;
         if_rvalid_reg  <= 1'b0;
         if_err_reg     <= 1'b0;
         if_rdata_reg   <= '0;
         d_rvalid_reg   <= 1'b0;
         d_err_reg      <= 1'b0;
         d_rdata_reg    <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         if_rvalid_reg  <= fetch_win;
         if_err_reg     <= fetch_win && if_bad;
         if_rdata_reg   <= (fetch_win && !if_bad) ? mem_rdata : '0;
         d_rvalid_reg   <= data_win;
         d_err_reg      <= data_win && d_bad;
         d_rdata_reg    <= (data_win && !d_bad && !d_we) ? mem_rdata : '0;
      end
   end

   assign if_rvalid = if_rvalid_reg;
   assign if_err    = if_err_reg;
   assign if_rdata  = if_rdata_reg;
   assign d_rvalid  = d_rvalid_reg;
   assign d_err     = d_err_reg;
   assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 4 KB memory model, directed scenarios and a randomized
// run checked against a reference arbitration/memory model.
module tb_mem_port_arbiter;

   localparam int MEMB  = 4096;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [2:0]  d_func3;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_func3;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] mem     [MEMB];
   logic [7:0] ref_mem [MEMB];

   mem_port_arbiter #(.MEM_BYTES(MEMB), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] extend(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b100:  return {24'h0, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   // Memory model: combinational read with func3 extension, posedge byte-enabled write.
   assign mem_rdata = extend(mem[mem_addr[11:0]], mem[mem_addr[11:0] + 12'd1],
                             mem[mem_addr[11:0] + 12'd2], mem[mem_addr[11:0] + 12'd3], mem_func3);

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[11:0]] <= mem_wdata[7:0];
         if (mem_func3[1:0] != 2'b00) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
         if (mem_func3[1:0] == 2'b10) begin
            mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
            mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
         end
      end
   end

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
      logic [11:0] x;
      x = a[11:0];
      return extend(ref_mem[x], ref_mem[x + 12'd1], ref_mem[x + 12'd2], ref_mem[x + 12'd3], f3);
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
      int n;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[(a[11:0] + i) % MEMB] = wd[8*i +: 8];
   endtask

   function automatic bit ref_err(input bit is_fetch, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a);
      int size;
      bit ok;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (is_fetch) ok = 1'b1;
      else if (we)  ok = f3 inside {3'd0, 3'd1, 3'd2};
      else          ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      return !ok || ({32'h0, a} > 64'(MEMB - size));
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      if_req = 0; d_req = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_func3 = 0; d_wdata = 0;
   endtask

   task automatic test_reset;
      rst_n = 0;
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 1; d_addr = 32'h80;
      d_func3 = 3'b010; d_wdata = 32'hA5A5A5A5;
      tick; tick;
      n_cmp++; if ({if_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {if_gnt, d_gnt}); end
      n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 00", {mem_read, mem_write}); end
      n_cmp++; if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", {if_rvalid, d_rvalid, if_err, d_err}); end
      n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
      d_we = 0;
      rst_n = 1;
      #1;
      n_cmp++; if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL reset_release_arb: got %b want 01", {if_gnt, d_gnt}); end
      tick;
      idle;
      tick;
   endtask

   task automatic test_roundtrip;
      d_req = 1; d_we = 1; d_addr = 32'h100; d_func3 = 3'b010; d_wdata = 32'hDEADBEEF;
      #1;
      n_cmp++; if ({d_gnt, mem_write, mem_read} !== 3'b110) begin n_fail++; $display("FAIL sw_ctl: got %b want 110", {d_gnt, mem_write, mem_read}); end
      tick;
      ref_store(32'h100, 3'b010, 32'hDEADBEEF);
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL sw_ack: got v%b e%b %h want v1 e0 0", d_rvalid, d_err, d_rdata); end
      d_we = 0; d_addr = 32'h103; d_func3 = 3'b000;
      tick;
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hFFFFFFDE}) begin n_fail++; $display("FAIL lb: got v%b e%b %h want v1 e0 ffffffde", d_rvalid, d_err, d_rdata); end
      d_func3 = 3'b100;
      tick;
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h000000DE}) begin n_fail++; $display("FAIL lbu: got v%b e%b %h want v1 e0 000000de", d_rvalid, d_err, d_rdata); end
      idle;
      tick;
      n_cmp++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b want 0", d_rvalid); end
   endtask

   task automatic test_contention;
      if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h10; d_func3 = 3'b010;
      for (int c = 0; c < 10; c++) begin
         logic [1:0] want;
         want = (c == 4 || c == 9) ? 2'b10 : 2'b01;
         #1;
         n_cmp++; if ({if_gnt, d_gnt} !== want) begin n_fail++; $display("FAIL contention_c%0d: got %b want %b", c, {if_gnt, d_gnt}, want); end
         tick;
      end
      idle;
      tick;
   endtask

   task automatic test_range_error;
      d_req = 1; d_we = 0; d_addr = 32'hFFD; d_func3 = 3'b010;
      #1;
      n_cmp++; if ({d_gnt, mem_read, mem_write} !== 3'b100) begin n_fail++; $display("FAIL lw_range_ctl: got %b want 100", {d_gnt, mem_read, mem_write}); end
      tick;
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL lw_range_resp: got v%b e%b %h want v1 e1 0", d_rvalid, d_err, d_rdata); end
      d_addr = 32'hFFF; d_func3 = 3'b000;
      #1;
      n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL lb_edge_read: got %b want 1", mem_read); end
      tick;
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, ref_load(32'hFFF, 3'b000)}) begin n_fail++; $display("FAIL lb_edge_resp: got v%b e%b %h want v1 e0 %h", d_rvalid, d_err, d_rdata, ref_load(32'hFFF, 3'b000)); end
      idle;
      tick;
   endtask

   task automatic test_func3_error;
      d_req = 1; d_we = 1; d_addr = 32'h300; d_func3 = 3'b100; d_wdata = 32'h11223344;
      #1;
      n_cmp++; if ({d_gnt, mem_write} !== 2'b10) begin n_fail++; $display("FAIL sb_f3_ctl: got %b want 10", {d_gnt, mem_write}); end
      tick;
      n_cmp++; if ({d_rvalid, d_err} !== 2'b11) begin n_fail++; $display("FAIL sb_f3_err: got %b want 11", {d_rvalid, d_err}); end
      d_we = 0; d_func3 = 3'b011;
      tick;
      n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL ld_f3_err: got v%b e%b %h want v1 e1 0", d_rvalid, d_err, d_rdata); end
      idle;
      if_req = 1; if_addr = 32'h1000;
      #1;
      n_cmp++; if ({if_gnt, mem_read} !== 2'b10) begin n_fail++; $display("FAIL fetch_range_ctl: got %b want 10", {if_gnt, mem_read}); end
      tick;
      n_cmp++; if ({if_rvalid, if_err, if_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL fetch_range_err: got v%b e%b %h want v1 e1 0", if_rvalid, if_err, if_rdata); end
      n_cmp++; if (mem[12'h302] !== ref_mem[12'h302]) begin n_fail++; $display("FAIL sb_f3_mem: got %h want %h", mem[12'h302], ref_mem[12'h302]); end
      idle;
      tick;
   endtask

   task automatic test_mid_reset;
      d_req = 1; d_we = 1; d_addr = 32'h200; d_func3 = 3'b010; d_wdata = 32'h12345678;
      #1;
      n_cmp++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b want 1", d_gnt); end
      rst_n = 0;
      #1;
      n_cmp++; if ({d_gnt, mem_write} !== 2'b00) begin n_fail++; $display("FAIL midrst_gate: got %b want 00", {d_gnt, mem_write}); end
      tick;
      idle;
      rst_n = 1;
      tick;
      n_cmp++; if ({d_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid: got %b want 00", {d_rvalid, if_rvalid}); end
      n_cmp++; if ({mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} !==
                   {ref_mem[12'h203], ref_mem[12'h202], ref_mem[12'h201], ref_mem[12'h200]}) begin
         n_fail++; $display("FAIL midrst_mem: got %h%h%h%h want %h%h%h%h", mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200],
                            ref_mem[12'h203], ref_mem[12'h202], ref_mem[12'h201], ref_mem[12'h200]);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       return 32'($urandom_range(0, MEMB - 1));
      else if (r == 8) return 32'(MEMB - 8 + $urandom_range(0, 15));
      else             return $urandom;
   endfunction

   task automatic test_random;
      int starve;
      bit e_iv, e_ie, e_dv, e_de;
      logic [31:0] e_ird, e_drd;
      starve = 0;
      e_iv = 0; e_ie = 0; e_dv = 0; e_de = 0; e_ird = 0; e_drd = 0;
      for (int n = 0; n < 400; n++) begin
         bit fg, dg, ierr, derr;
         logic [31:0] x_addr, x_wdata;
         logic [2:0] x_f3;
         bit x_rd, x_wr;
         if_req  = ($urandom_range(0, 3) != 0);
         d_req   = ($urandom_range(0, 3) != 0);
         d_we    = $urandom_range(0, 1);
         if_addr = rand_addr();
         d_addr  = rand_addr();
         d_func3 = 3'($urandom_range(0, 7));
         d_wdata = $urandom;
         fg   = if_req && (!d_req || starve == LIMIT);
         dg   = d_req && !fg;
         ierr = ref_err(1, 0, 3'b010, if_addr);
         derr = ref_err(0, d_we, d_func3, d_addr);
         x_rd = (fg && !ierr) || (dg && !derr && !d_we);
         x_wr = dg && !derr && d_we;
         x_addr = 0; x_f3 = 0; x_wdata = 0;
         if (fg && !ierr) begin x_addr = if_addr; x_f3 = 3'b010; end
         if (dg && !derr) begin x_addr = d_addr; x_f3 = d_func3; end
         if (x_wr) x_wdata = d_wdata;
         #1;
         n_cmp++; if ({if_gnt, d_gnt, mem_read, mem_write} !== {fg, dg, x_rd, x_wr}) begin
            n_fail++; $display("FAIL rnd%0d_ctl: got ig/dg/rd/wr %b want %b", n, {if_gnt, d_gnt, mem_read, mem_write}, {fg, dg, x_rd, x_wr});
         end
         if (x_rd || x_wr || !(fg || dg)) begin
            n_cmp++; if ({mem_addr, mem_func3, mem_wdata} !== {x_addr, x_f3, x_wdata}) begin
               n_fail++; $display("FAIL rnd%0d_bus: got a%h f%0d w%h want a%h f%0d w%h", n, mem_addr, mem_func3, mem_wdata, x_addr, x_f3, x_wdata);
            end
         end
         e_iv = fg; e_ie = fg && ierr;
         e_ird = (fg && !ierr) ? ref_load(if_addr, 3'b010) : 32'h0;
         e_dv = dg; e_de = dg && derr;
         e_drd = (dg && !derr && !d_we) ? ref_load(d_addr, d_func3) : 32'h0;
         if (x_wr) ref_store(d_addr, d_func3, d_wdata);
         starve = (if_req && !fg) ? ((starve == LIMIT) ? LIMIT : starve + 1) : 0;
         tick;
         n_cmp++; if ({if_rvalid, if_err, if_rdata} !== {e_iv, e_ie, e_ird}) begin
            n_fail++; $display("FAIL rnd%0d_if_resp: got v%b e%b %h want v%b e%b %h", n, if_rvalid, if_err, if_rdata, e_iv, e_ie, e_ird);
         end
         n_cmp++; if ({d_rvalid, d_err, d_rdata} !== {e_dv, e_de, e_drd}) begin
            n_fail++; $display("FAIL rnd%0d_d_resp: got v%b e%b %h want v%b e%b %h", n, d_rvalid, d_err, d_rdata, e_dv, e_de, e_drd);
         end
      end
      idle;
      tick;
   endtask

   initial begin
      for (int i = 0; i < MEMB; i++) begin
         mem[i]     = 8'((i * 37 + 11) ^ (i >> 3));
         ref_mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
      end
      idle;
      rst_n = 0;
      test_reset;
      test_roundtrip;
      test_contention;
      test_range_error;
      test_func3_error;
      test_mid_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
